// File: rtl/tile_layer_mixer.sv
// Multi-layer tile pixel pipeline. Each layer has a 16-dot shift register with tile load,
// flip and fine scroll. A two-stage registered mixer then picks the topmost opaque layer.
module tile_layer_mixer #(
    parameter int LAYERS          = 3,
    parameter int PIXEL_WIDTH     = 4,
    parameter int PALETTE_WIDTH   = 8,
    parameter int TRANSPARENT_PEN = 0,
    localparam int IDXW           = (LAYERS > 1) ? $clog2(LAYERS) : 1,
    localparam int DOT_WIDTH      = PALETTE_WIDTH + PIXEL_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              ce_pixel,
    input  logic                              flush,
    input  logic [LAYERS-1:0]                 load,
    input  logic [LAYERS*8*PIXEL_WIDTH-1:0]   gfx_in,
    input  logic [LAYERS*PALETTE_WIDTH-1:0]   palette_in,
    input  logic [LAYERS-1:0]                 flip_x,
    input  logic [LAYERS*3-1:0]               fine_x,
    input  logic [LAYERS-1:0]                 layer_en,
    input  logic [LAYERS*IDXW-1:0]            prio_order,
    input  logic [DOT_WIDTH-1:0]              backdrop,
    output logic [DOT_WIDTH-1:0]              dot_out,
    output logic [IDXW-1:0]                   layer_out,
    output logic                              opaque_out
);

    localparam int NSEL = 1 << IDXW;
    localparam logic [PIXEL_WIDTH-1:0] C_TPEN = PIXEL_WIDTH'(TRANSPARENT_PEN);

    logic [DOT_WIDTH-1:0] r_ent     [LAYERS][16];
    logic [DOT_WIDTH-1:0] w_tile    [LAYERS][8];
    logic [DOT_WIDTH-1:0] w_raw     [LAYERS];
    logic [DOT_WIDTH-1:0] r_dot_a   [LAYERS];
    logic [LAYERS-1:0]    r_op_a;
    logic [NSEL-1:0]      w_op_sel;
    logic                 w_found;
    logic [IDXW-1:0]      w_win;
    logic [DOT_WIDTH-1:0] w_win_dot;

    // Tile dots as they land in e[7:0], with the flip applied
    always_comb begin
        for (int i = 0; i < LAYERS; i++) begin
            for (int j = 0; j < 8; j++) begin
                w_tile[i][j] = {palette_in[i*PALETTE_WIDTH +: PALETTE_WIDTH],
                                gfx_in[i*8*PIXEL_WIDTH + (flip_x[i] ? 7 - j : j)*PIXEL_WIDTH +: PIXEL_WIDTH]};
            end
        end
    end

    // Dot shift registers: shift every pixel, load overwrites the low half, flush clears all
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LAYERS; i++) begin
                for (int k = 0; k < 16; k++) begin
                    r_ent[i][k] <= '0;
                end
            end
        end else if (ce_pixel) begin
            for (int i = 0; i < LAYERS; i++) begin
                r_ent[i][0] <= (!flush && load[i]) ? w_tile[i][0] : '0;
                for (int k = 1; k < 8; k++) begin
                    r_ent[i][k] <= flush ? '0 : (load[i] ? w_tile[i][k] : r_ent[i][k-1]);
                end
                for (int k = 8; k < 16; k++) begin
                    r_ent[i][k] <= flush ? '0 : r_ent[i][k-1];
                end
            end
        end
    end

    // Fine-scroll tap: each fine_x step reads one entry earlier in the chain
    always_comb begin
        for (int i = 0; i < LAYERS; i++) begin
            w_raw[i] = r_ent[i][4'd15 - {1'b0, fine_x[i*3 +: 3]}];
        end
    end

    // Stage A: capture tapped dot and its opacity
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LAYERS; i++) begin
                r_dot_a[i] <= '0;
            end
            r_op_a <= '0;
        end else if (ce_pixel) begin
            for (int i = 0; i < LAYERS; i++) begin
                r_dot_a[i] <= w_raw[i];
                r_op_a[i]  <= layer_en[i] & (w_raw[i][PIXEL_WIDTH-1:0] != C_TPEN);
            end
        end
    end

    // Priority scan; out-of-range field values index zero-padded opacity bits and never win
    always_comb begin
        w_op_sel  = NSEL'(r_op_a);
        w_found   = 1'b0;
        w_win     = '0;
        for (int k = 0; k < LAYERS; k++) begin
            if (!w_found && w_op_sel[prio_order[k*IDXW +: IDXW]]) begin
                w_found = 1'b1;
                w_win   = prio_order[k*IDXW +: IDXW];
            end else begin
                w_win   = w_win;
            end
        end
        w_win_dot = '0;
        for (int i = 0; i < LAYERS; i++) begin
            w_win_dot = (w_win == IDXW'(i)) ? r_dot_a[i] : w_win_dot;
        end
    end

    // Stage B: registered mixer output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dot_out    <= '0;
            layer_out  <= '0;
            opaque_out <= 1'b0;
        end else if (ce_pixel) begin
            if (w_found) begin
                dot_out    <= w_win_dot;
                layer_out  <= w_win;
                opaque_out <= 1'b1;
            end else begin
                dot_out    <= backdrop;
                layer_out  <= '0;
                opaque_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tile_layer_mixer.sv
// Directed bench for tile_layer_mixer: a timeline model of each layer's dot stream is
// compared against the DUT every clock, plus hand-computed literal pins.
module tb_tile_layer_mixer;

    localparam int L   = 3;
    localparam int PW  = 4;
    localparam int PLW = 8;
    localparam int DW  = 12;
    localparam int IW  = 2;
    localparam int TLN = 2048;

    logic            clk = 1'b0;
    logic            reset_n, ce_pixel, flush;
    logic [L-1:0]    load, flip_x, layer_en;
    logic [L*32-1:0] gfx_in;
    logic [L*PLW-1:0] palette_in;
    logic [L*3-1:0]  fine_x;
    logic [L*IW-1:0] prio_order;
    logic [DW-1:0]   backdrop;
    logic [DW-1:0]   dot_out;
    logic [IW-1:0]   layer_out;
    logic            opaque_out;

    tile_layer_mixer dut (
        .clk(clk), .reset_n(reset_n), .ce_pixel(ce_pixel), .flush(flush), .load(load),
        .gfx_in(gfx_in), .palette_in(palette_in), .flip_x(flip_x), .fine_x(fine_x),
        .layer_en(layer_en), .prio_order(prio_order), .backdrop(backdrop),
        .dot_out(dot_out), .layer_out(layer_out), .opaque_out(opaque_out)
    );

    always #5 clk = ~clk;

    // Model: tl[i][t] is the dot that sits in e[p] after ce edge t+p (entry injected at edge t).
    logic [DW-1:0] tl [L][TLN];
    logic [DW-1:0] m_a_dot [L];
    logic          m_a_op  [L];
    logic [DW-1:0] exp_dot;
    logic [IW-1:0] exp_layer;
    logic          exp_op;
    int            cnt = 16;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < L; i++) begin
            for (int t = 0; t < TLN; t++) tl[i][t] = '0;
            m_a_dot[i] = '0;
            m_a_op[i]  = 1'b0;
        end
        exp_dot = '0; exp_layer = '0; exp_op = 1'b0;
    endtask

    task automatic model_edge();
        logic          found;
        logic [DW-1:0] nd;
        logic [IW-1:0] nl, v;
        logic [DW-1:0] d;
        int            f;
        found = 1'b0; nd = backdrop; nl = '0;
        for (int k = 0; k < L; k++) begin
            v = prio_order[k*IW +: IW];
            if (!found && int'(v) < L) begin
                if (m_a_op[v]) begin
                    found = 1'b1; nd = m_a_dot[v]; nl = v;
                end
            end
        end
        for (int i = 0; i < L; i++) begin
            f = int'(fine_x[i*3 +: 3]);
            d = tl[i][cnt - 16 + f];
            m_a_dot[i] = d;
            m_a_op[i]  = layer_en[i] && (d[PW-1:0] != 4'h0);
        end
        for (int i = 0; i < L; i++) begin
            if (flush) begin
                for (int p = 0; p < 16; p++) tl[i][cnt - p] = '0;
            end else if (load[i]) begin
                for (int j = 0; j < 8; j++)
                    tl[i][cnt - j] = {palette_in[i*PLW +: PLW],
                                      gfx_in[i*32 + (flip_x[i] ? 7 - j : j)*PW +: PW]};
            end
        end
        cnt++;
        exp_dot = nd; exp_layer = nl; exp_op = found;
    endtask

    // One clock: advance the model on ce edges, then compare all outputs after the edge
    task automatic tick();
        if (reset_n && ce_pixel) model_edge();
        @(posedge clk);
        #1;
        chk("dot_out", dot_out, exp_dot);
        chk("layer_out", layer_out, exp_layer);
        chk("opaque_out", opaque_out, exp_op);
    endtask

    task automatic set_tile(input int i, input logic [31:0] g, input logic [7:0] p);
        gfx_in[i*32 +: 32]     = g;
        palette_in[i*PLW +: PLW] = p;
    endtask

    initial begin
        reset_n = 1'b1; ce_pixel = 1'b0; flush = 1'b0; load = '0; flip_x = '0;
        layer_en = 3'b111; gfx_in = '0; palette_in = '0; fine_x = '0;
        prio_order = {2'd2, 2'd1, 2'd0}; backdrop = 12'h0A5;
        model_reset();
        #1 reset_n = 1'b0;
        #2;
        chk("rst_dot", dot_out, 12'h000);
        chk("rst_opq", opaque_out, 1'b0);
        ce_pixel = 1'b1;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("idle_backdrop", dot_out, 12'h0A5);

        // load latency and pixel order
        set_tile(0, 32'h87654321, 8'h3C);
        load = 3'b001; tick(); load = '0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 10) begin chk("lat_first", dot_out, 12'h3C8); chk("lat_opq", opaque_out, 1'b1); end
            if (k == 17) chk("lat_last", dot_out, 12'h3C1);
            if (k == 18) chk("lat_after", dot_out, 12'h0A5);
        end

        // horizontal flip with fine scroll 3
        flip_x = 3'b001; fine_x = 9'd3;
        load = 3'b001; tick(); load = '0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 6)  chk("flip_before", dot_out, 12'h0A5);
            if (k == 7)  chk("flip_first", dot_out, 12'h3C1);
            if (k == 11) chk("flip_mid", dot_out, 12'h3C5);
            if (k == 14) chk("flip_last", dot_out, 12'h3C8);
        end
        flip_x = '0; fine_x = '0;

        // priority: field0=1, field1=0, field2=2
        prio_order = {2'd2, 2'd0, 2'd1};
        set_tile(0, 32'h11111111, 8'h10);
        set_tile(1, 32'h22222222, 8'h20);
        set_tile(2, 32'h33333333, 8'h30);
        load = 3'b111; tick(); load = '0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 11) layer_en = 3'b101;
            tick();
            if (k == 10) begin chk("prio_l1", layer_out, 2'd1); chk("prio_l1_dot", dot_out, 12'h202); end
            if (k == 12) begin chk("prio_l0", layer_out, 2'd0); chk("prio_l0_dot", dot_out, 12'h101); end
        end
        // layer 0 transparent, layer 1 disabled, field value 3 skipped
        prio_order = {2'd2, 2'd3, 2'd1};
        set_tile(0, 32'h00000000, 8'h10);
        load = 3'b111; tick(); load = '0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 10) begin chk("prio_l2", layer_out, 2'd2); chk("prio_l2_dot", dot_out, 12'h303); end
        end
        layer_en = 3'b111; prio_order = {2'd2, 2'd1, 2'd0};

        // flush wins over a simultaneous load
        set_tile(0, 32'h87654321, 8'h3C);
        load = 3'b001; tick(); load = '0;
        repeat (3) tick();
        set_tile(0, 32'h99999999, 8'h11);
        load = 3'b111; flush = 1'b1; tick(); load = '0; flush = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("flush_bd", dot_out, 12'h0A5);
        end

        // asynchronous reset mid-tile
        set_tile(0, 32'h87654321, 8'h3C);
        load = 3'b001; tick(); load = '0;
        repeat (11) tick();
        chk("pre_rst_opq", opaque_out, 1'b1);
        reset_n = 1'b0;
        #2;
        chk("midrst_dot", dot_out, 12'h000);
        chk("midrst_opq", opaque_out, 1'b0);
        model_reset();
        tick();
        reset_n = 1'b1;
        repeat (4) tick();

        // ce gating inside a tile stretches the sequence
        set_tile(0, 32'hFEDCBA98, 8'h5A);
        load = 3'b001; tick(); load = '0;
        for (int k = 1; k <= 24; k++) begin
            ce_pixel = (k >= 12 && k <= 14) ? 1'b0 : 1'b1;
            tick();
            if (k == 10) chk("gate_first", dot_out, 12'h5AF);
            if (k == 13) chk("gate_hold", dot_out, 12'h5AE);
            if (k == 15) chk("gate_resume", dot_out, 12'h5AD);
        end
        ce_pixel = 1'b1;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
